// File: rtl/bnn_threshold_packer.sv
// Binarised-NN activation stage: compares NUM_PES accumulator results against a
// per-PE threshold/invert table, LANES at a time, and emits one packed bit word per pass.

module bnn_lane_cmp #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] res,
    input  logic [ACC_W-1:0] thr,
    input  logic             inv,
    output logic             bit_out
);
    assign bit_out = (res >= thr) ^ inv;
endmodule

module bnn_threshold_packer #(
    parameter int NUM_PES = 64,
    parameter int ACC_W   = 16,
    parameter int LANES   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_done,
    input  logic [NUM_PES*ACC_W-1:0] results_in,
    input  logic                     thr_wr_en,
    input  logic [5:0]               thr_wr_idx,
    input  logic [ACC_W-1:0]         thr_wr_data,
    input  logic                     thr_wr_inv,
    input  logic                     addr_clr,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_PES-1:0]       out_data,
    output logic [5:0]               out_addr,
    output logic                     overflow
);
    localparam int GROUPS = NUM_PES / LANES;
    localparam int LC_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(GROUPS - 1);

    typedef enum logic [1:0] {IDLE, CMP, OUT} state_t;

    state_t state_q, state_d;
    logic [LC_W-1:0] lc_q;
    logic in_done_q;
    logic trig;
    logic fire;
    logic out_valid_q;
    logic [5:0] addr_q;
    logic ovf_q;

    // Grouped views: [group][lane] so the lane counter selects a whole group directly.
    logic [GROUPS-1:0][LANES-1:0][ACC_W-1:0] res_q;
    logic [GROUPS-1:0][LANES-1:0][ACC_W-1:0] thr_q;
    logic [GROUPS-1:0][LANES-1:0]            inv_q;
    logic [GROUPS-1:0][LANES-1:0]            data_q;
    logic [LANES-1:0]                        lane_bits;

    assign trig      = in_done & ~in_done_q;
    assign fire      = out_valid_q & out_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign overflow  = ovf_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        bnn_lane_cmp #(.ACC_W(ACC_W)) u_cmp (
            .res    (res_q[lc_q][k]),
            .thr    (thr_q[lc_q][k]),
            .inv    (inv_q[lc_q][k]),
            .bit_out(lane_bits[k])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trig) state_d = CMP;
            CMP:     if (lc_q == LC_LAST) state_d = OUT;
            OUT:     if (fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lc_q        <= '0;
            in_done_q   <= 1'b0;
            res_q       <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            addr_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            in_done_q <= in_done;
            // A trigger outside IDLE is lost, including one that coincides with a handshake.
            if (trig && state_q != IDLE) ovf_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        res_q <= results_in;
                        lc_q  <= '0;
                    end
                    if (addr_clr) addr_q <= '0;
                end
                CMP: begin
                    data_q[lc_q] <= lane_bits;
                    lc_q         <= lc_q + 1'b1;
                    if (lc_q == LC_LAST) out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (fire) begin
                        out_valid_q <= 1'b0;
                        addr_q      <= addr_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table writes are accepted in any state; a compare in flight sees the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_q <= '0;
            inv_q <= '0;
        end else if (thr_wr_en) begin
            for (int g = 0; g < GROUPS; g++) begin
                for (int k = 0; k < LANES; k++) begin
                    if (thr_wr_idx == 6'(g * LANES + k)) begin
                        thr_q[g][k] <= thr_wr_data;
                        inv_q[g][k] <= thr_wr_inv;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_bnn_threshold_packer.sv
// Directed bench for bnn_threshold_packer: table of single-pass compare vectors plus
// hand-written sequences for stall, address wrap, overflow, reset abort and write races.

module tb_bnn_threshold_packer;
    localparam int NP = 64;
    localparam int AW = 16;
    localparam int LN = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_done;
    logic [NP*AW-1:0]   results_in;
    logic               thr_wr_en;
    logic [5:0]         thr_wr_idx;
    logic [AW-1:0]      thr_wr_data;
    logic               thr_wr_inv;
    logic               addr_clr;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [NP-1:0]      out_data;
    logic [5:0]         out_addr;
    logic               overflow;

    int tests = 0;
    int fails = 0;

    bnn_threshold_packer #(.NUM_PES(NP), .ACC_W(AW), .LANES(LN)) dut (
        .clk(clk), .reset(reset), .in_done(in_done), .results_in(results_in),
        .thr_wr_en(thr_wr_en), .thr_wr_idx(thr_wr_idx), .thr_wr_data(thr_wr_data),
        .thr_wr_inv(thr_wr_inv), .addr_clr(addr_clr), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          mode;      // 0: all res_val, 1: 99+(i%2), 2: res[i]=i
        logic [15:0] res_val;
        logic [15:0] thr_val;
        logic        inv_all;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    function automatic logic [NP*AW-1:0] make_res(input int mode, input logic [15:0] v);
        logic [NP*AW-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) begin
            case (mode)
                1:       r[i*AW +: AW] = 16'(99 + (i % 2));
                2:       r[i*AW +: AW] = 16'(i);
                default: r[i*AW +: AW] = v;
            endcase
        end
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1; in_done = 1'b0; out_ready = 1'b0; addr_clr = 1'b0; thr_wr_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_thr(input int idx, input logic [15:0] d, input logic iv);
        thr_wr_en = 1'b1; thr_wr_idx = 6'(idx); thr_wr_data = d; thr_wr_inv = iv;
        tick();
        thr_wr_en = 1'b0;
    endtask

    task automatic set_all_thr(input logic [15:0] d, input logic iv);
        for (int i = 0; i < NP; i++) write_thr(i, d, iv);
    endtask

    // Ticks until out_valid is seen; bounded so a dead DUT cannot hang the run.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 30);
    endtask

    task automatic finish_pass();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_done = 1'b0;
        tick();
    endtask

    task automatic run_pass(input logic [NP*AW-1:0] res, output logic [63:0] d,
                            output logic [5:0] a, output int lat);
        int n;
        results_in = res;
        in_done = 1'b1;
        wait_valid(n);
        lat = n - 1;
        d = out_data;
        a = out_addr;
        finish_pass();
    endtask

    initial begin
        logic [63:0] d, saved_d;
        logic [5:0]  a, saved_a;
        int lat, n, bad, cnt;
        int addr_model;

        vecs[0] = '{"zero_res_zero_thr", 0, 16'h0000, 16'h0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{"alt_99_100_thr100", 1, 16'h0000, 16'd100,  1'b0, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[2] = '{"max_equal",         0, 16'hFFFF, 16'hFFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{"unsigned_below",    0, 16'h7FFF, 16'h8000, 1'b0, 64'h0000_0000_0000_0000};
        vecs[4] = '{"unsigned_above",    0, 16'h8000, 16'h7FFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{"index_vs_thr1",     2, 16'h0000, 16'h0001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[6] = '{"inv_all_equal",     0, 16'h0010, 16'h0010, 1'b1, 64'h0000_0000_0000_0000};

        results_in = '0; thr_wr_idx = '0; thr_wr_data = '0; thr_wr_inv = 1'b0;
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        check("rst_out_addr",  64'(out_addr),  64'd0);
        check("rst_out_data",  out_data,       64'd0);

        // Table-driven single passes; out_addr advances once per pass.
        addr_model = 0;
        for (int v = 0; v < 7; v++) begin
            set_all_thr(vecs[v].thr_val, vecs[v].inv_all);
            run_pass(make_res(vecs[v].mode, vecs[v].res_val), d, a, lat);
            check({vecs[v].name, "_data"},    d,         vecs[v].exp_data);
            check({vecs[v].name, "_addr"},    64'(a),    64'(addr_model));
            check({vecs[v].name, "_latency"}, 64'(lat),  64'd8);
            addr_model++;
        end
        check("addr_after_table", 64'(out_addr), 64'd7);
        check("no_overflow_table", 64'(overflow), 64'd0);

        // Single inverted entry with a zero threshold.
        do_reset();
        write_thr(5, 16'h0000, 1'b1);
        run_pass(make_res(0, 16'h0000), d, a, lat);
        check("inv5_data", d, 64'hFFFF_FFFF_FFFF_FFDF);
        check("inv5_addr", 64'(a), 64'd0);

        // Threshold write on the same edge that compares index 0 uses the old value.
        results_in = make_res(0, 16'd5);
        in_done = 1'b1;
        tick();
        thr_wr_en = 1'b1; thr_wr_idx = 6'd0; thr_wr_data = 16'd6; thr_wr_inv = 1'b0;
        tick();
        thr_wr_en = 1'b0;
        wait_valid(n);
        check("race_latency_rest", 64'(n), 64'd7);
        check("race_old_thr", out_data, 64'hFFFF_FFFF_FFFF_FFDF);
        finish_pass();
        run_pass(make_res(0, 16'd5), d, a, lat);
        check("race_new_thr", d, 64'hFFFF_FFFF_FFFF_FFDE);

        // Backpressure: 20 stalled cycles, then one transfer.
        results_in = make_res(2, 16'h0000);
        in_done = 1'b1;
        wait_valid(n);
        saved_d = out_data;
        saved_a = out_addr;
        check("stall_data", saved_d, 64'hFFFF_FFFF_FFFF_FFDE);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== saved_d || out_addr !== saved_a) bad++;
        end
        check("stall_stable", 64'(bad), 64'd0);
        out_ready = 1'b1;
        tick();
        check("stall_xfer_valid", 64'(out_valid), 64'd0);
        check("stall_xfer_addr",  64'(out_addr),  64'(saved_a + 6'd1));
        out_ready = 1'b0;
        in_done = 1'b0;
        tick();
        check("stall_idle", 64'(busy), 64'd0);

        // 64 passes walk out_addr 0..63 and wrap to 0.
        do_reset();
        bad = 0;
        for (int p = 0; p < 64; p++) begin
            run_pass(make_res(0, 16'h0000), d, a, lat);
            if (a !== 6'(p)) bad++;
        end
        check("addr_seq", 64'(bad), 64'd0);
        check("addr_wrap", 64'(out_addr), 64'd0);
        run_pass(make_res(0, 16'h0000), d, a, lat);
        in_done = 1'b1;
        tick();
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        wait_valid(n);
        check("addr_clr_ignored", 64'(out_addr), 64'd1);
        finish_pass();
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        check("addr_clr_idle", 64'(out_addr), 64'd0);

        // Second rising done during CMP is dropped; exactly one word comes out.
        do_reset();
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        tick();
        in_done = 1'b1;
        tick();
        check("ovf_set", 64'(overflow), 64'd1);
        in_done = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (out_valid) cnt++;
        end
        out_ready = 1'b0;
        check("ovf_one_word", 64'(cnt), 64'd1);

        // Reset mid-CMP aborts the pass and clears overflow immediately.
        in_done = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort_busy",     64'(busy),     64'd0);
        check("abort_overflow", 64'(overflow), 64'd0);
        in_done = 1'b0;
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid) cnt++;
        end
        check("abort_no_valid", 64'(cnt), 64'd0);
        run_pass(make_res(0, 16'h0000), d, a, lat);
        check("abort_next_latency", 64'(lat), 64'd8);
        check("abort_next_data", d, 64'hFFFF_FFFF_FFFF_FFFF);

        // Trigger on the handshake edge counts as dropped.
        do_reset();
        in_done = 1'b1;
        wait_valid(n);
        in_done = 1'b0;
        tick();
        in_done = 1'b1;
        out_ready = 1'b1;
        tick();
        check("hs_trig_overflow", 64'(overflow), 64'd1);
        check("hs_trig_busy",     64'(busy),     64'd0);
        out_ready = 1'b0;
        in_done = 1'b0;
        tick();

        // Done already high when reset releases fires on the first edge.
        in_done = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_valid(n);
        check("done_at_release_latency", 64'(n - 1), 64'd8);
        finish_pass();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bnn_threshold_packer.md
BNN_THRESHOLD_PACKER -- requirements
Module: bnn_threshold_packer

Interface
REQ-001 SHALL have parameter NUM_PES, default 64, meaning the number of accumulator results per layer pass.
REQ-002 SHALL have parameter ACC_W, default 16, meaning the width of each accumulator result and threshold.
REQ-003 SHALL have parameter LANES, default 8, meaning the number of results compared per cycle; NUM_PES SHALL be a multiple of LANES.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_done, input, 1 bit: the upstream array "done" level.
REQ-007 SHALL have port results_in, input, NUM_PES*ACC_W bits: the unsigned accumulator results; result i occupies bits [(i+1)*ACC_W-1 : i*ACC_W].
REQ-008 SHALL have the threshold write port: thr_wr_en (input, 1 bit), thr_wr_idx (input, 6 bits), thr_wr_data (input, ACC_W bits), thr_wr_inv (input, 1 bit).
REQ-009 SHALL have port addr_clr, input, 1 bit: synchronous clear of out_addr.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have the output handshake: out_valid (output, 1 bit), out_ready (input, 1 bit), out_data (output, NUM_PES bits), out_addr (output, 6 bits).
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag for a dropped input.

Function
REQ-013 SHALL hold a threshold table thr[0..NUM_PES-1] (ACC_W bits) and an invert table inv[0..NUM_PES-1] (1 bit); thr_wr_en writes both entries at thr_wr_idx on the clock edge, in any state.
REQ-014 SHALL register in_done as in_done_q; a trigger is in_done high while in_done_q is low, so a held-high done level produces exactly one trigger.
REQ-015 SHALL implement states IDLE, CMP and OUT.
REQ-016 On a trigger in IDLE: SHALL capture results_in into an internal register, clear lane counter lc to 0, and enter CMP.
REQ-017 In CMP, each edge: for k in 0..LANES-1 with i = lc*LANES+k, SHALL set out_data[i] = (res[i] >= thr[i]) XOR inv[i], using an unsigned compare; SHALL then increment lc.
REQ-018 The edge that processes lc = NUM_PES/LANES-1 SHALL move the state to OUT and set out_valid to 1.
REQ-019 Latency: out_valid SHALL be high after exactly NUM_PES/LANES edges following the trigger-accepting edge (8 at defaults).
REQ-020 A threshold written on the same edge that compares that index SHALL NOT affect that compare; the compare uses the old value.
REQ-021 In OUT: out_data and out_addr SHALL remain stable while out_valid is high and out_ready is low.
REQ-022 On the edge where out_valid and out_ready are both high: SHALL clear out_valid, increment out_addr modulo 64 (63 wraps to 0), and return to IDLE.
REQ-023 A trigger arriving while the state is not IDLE SHALL be dropped and SHALL set overflow to 1; overflow stays high until reset.
REQ-024 addr_clr SHALL set out_addr to 0 only in IDLE; in any other state it SHALL be ignored.
REQ-025 If a handshake completes on the same edge as a trigger, the trigger SHALL be counted as dropped (overflow set), because the state was not IDLE on that edge.

Reset
REQ-026 reset high SHALL immediately set: state IDLE, lc 0, in_done_q 0, out_valid 0, out_data 0, out_addr 0, overflow 0, busy 0, and all thr and inv entries 0.
REQ-027 Reset asserted mid-CMP or mid-OUT SHALL abort the pass with no out_valid pulse; the first trigger after release SHALL be processed normally.
REQ-028 Because of REQ-026, if in_done is already high when reset releases, a trigger SHALL fire on the first edge after release.

Verification
REQ-029 Scenario, defaults after reset, no threshold writes: results all 0x0000, in_done raised -> out_valid high 8 edges later, out_data = all ones, out_addr = 0.
REQ-030 Scenario: thr[i] = 100 for all i, res[i] = 99 + (i%2), out_ready held high -> out_data = 0xAAAA_AAAA_AAAA_AAAA; out_addr reads 1 afterwards.
REQ-031 Scenario: inv[5] = 1 with thr[5] = 0, all others default -> out_data = all ones except bit 5 = 0.
REQ-032 Scenario: out_ready held low for 20 cycles -> out_valid, out_data and out_addr stay constant; one transfer occurs when out_ready rises.
REQ-033 Scenario: 64 passes with out_addr starting at 0 -> out_addr sequence 0..63, then wraps to 0; addr_clr asserted in IDLE -> out_addr = 0.
REQ-034 Scenario: second in_done rising edge during CMP -> overflow = 1, exactly one output word; reset asserted during CMP -> no out_valid, overflow cleared.
